// File: rtl/adc_code_averager_pkg.sv
// Shared types and constants for the ADC code averaging path.
// Holds the code type, the min-tracker seed and the width helper.
package adc_pkg;

  localparam int unsigned ADC_CODE_W = 10;

  typedef logic [ADC_CODE_W-1:0] adc_code_t;

  localparam adc_code_t ADC_MIN_SEED = '1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/adc_code_averager_if.sv
// Result handshake between the averager and the readout side.
interface adc_code_averager_if #(
  parameter int unsigned CODE_W = 10
);

  logic [CODE_W-1:0] avg_o;
  logic [CODE_W-1:0] min_o;
  logic [CODE_W-1:0] max_o;
  logic              avg_valid_o;
  logic              avg_ready_i;

  modport master (
    output avg_o, min_o, max_o, avg_valid_o,
    input  avg_ready_i
  );

  modport slave (
    input  avg_o, min_o, max_o, avg_valid_o,
    output avg_ready_i
  );

endinterface

// File: rtl/adc_minmax_tracker.sv
// Running min/max over the current window; *_nx_o already include the
// code being accepted this cycle so the window's last sample is counted.
module adc_minmax_tracker
  import adc_pkg::*;
#(
  parameter int unsigned CODE_W = ADC_CODE_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [CODE_W-1:0] code_i,
  output logic [CODE_W-1:0] min_nx_o,
  output logic [CODE_W-1:0] max_nx_o
);

  logic [CODE_W-1:0] run_min_q, run_min_d;
  logic [CODE_W-1:0] run_max_q, run_max_d;

  always_comb begin
    min_nx_o = run_min_q;
    max_nx_o = run_max_q;
    if (accept_i && (code_i < run_min_q)) min_nx_o = code_i;
    if (accept_i && (code_i > run_max_q)) max_nx_o = code_i;

    run_min_d = min_nx_o;
    run_max_d = max_nx_o;
    if (clear_i) begin
      run_min_d = '1;
      run_max_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_min_q <= '1;
      run_max_q <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
    end
  end

endmodule

// File: rtl/adc_code_averager.sv
// Averages windows of 2^LOG2_AVG ADC codes into a 1-deep result register
// with valid/ready handshake, min/max capture and sticky overrun.
module adc_code_averager
  import adc_pkg::*;
#(
  parameter  int unsigned CODE_W   = ADC_CODE_W,
  parameter  int unsigned LOG2_AVG = 4,
  localparam int unsigned CNT_W    = clog2(32'd1 << LOG2_AVG) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              enable_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              code_valid_i,
  input  logic              clr_ovr_i,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  win_cnt_o,
  adc_code_averager_if.master res
);

  localparam int unsigned      ACC_W    = CODE_W + LOG2_AVG;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((32'd1 << LOG2_AVG) - 32'd1);

  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CODE_W-1:0] avg_q, avg_d;
  logic [CODE_W-1:0] min_q, min_d;
  logic [CODE_W-1:0] max_q, max_d;
  logic [CODE_W-1:0] win_min, win_max;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              accept, complete, load, drop, trk_clear;

  adc_minmax_tracker #(
    .CODE_W (CODE_W)
  ) u_minmax (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .clear_i  (trk_clear),
    .accept_i (accept),
    .code_i   (code_i),
    .min_nx_o (win_min),
    .max_nx_o (win_max)
  );

  always_comb begin
    accept    = enable_i && code_valid_i;
    complete  = accept && (win_cnt_q == WIN_LAST);
    trk_clear = !enable_i || complete;
    sum       = acc_q + ACC_W'(code_i);
    // A consumer handshake in the completion cycle frees the slot in time.
    load      = complete && (!valid_q || res.avg_ready_i);
    drop      = complete && !load;

    acc_d     = acc_q;
    win_cnt_d = win_cnt_q;
    if (trk_clear) begin
      acc_d     = '0;
      win_cnt_d = '0;
    end else if (accept) begin
      acc_d     = sum;
      win_cnt_d = win_cnt_q + CNT_W'(1);
    end

    avg_d   = avg_q;
    min_d   = min_q;
    max_d   = max_q;
    valid_d = valid_q;
    if (load) begin
      avg_d   = CODE_W'(sum >> LOG2_AVG);
      min_d   = win_min;
      max_d   = win_max;
      valid_d = 1'b1;
    end else if (valid_q && res.avg_ready_i) begin
      valid_d = 1'b0;
    end

    ovr_d = ovr_q;
    if (drop)           ovr_d = 1'b1;
    else if (clr_ovr_i) ovr_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      acc_q     <= '0;
      win_cnt_q <= '0;
      avg_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
      avg_q     <= avg_d;
      min_q     <= min_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign res.avg_o       = avg_q;
  assign res.min_o       = min_q;
  assign res.max_o       = max_q;
  assign res.avg_valid_o = valid_q;
  assign overrun_o       = ovr_q;
  assign win_cnt_o       = win_cnt_q;

endmodule

// File: tb/tb_adc_code_averager.sv
// Randomized and directed bench for adc_code_averager against a window-level model.
module tb_adc_code_averager;
  import adc_pkg::*;

  localparam int unsigned L2  = 4;
  localparam int unsigned WIN = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cv = 1'b0;
  logic       clr = 1'b0;
  logic [9:0] code = '0;
  logic [4:0] wcnt;
  logic       ovr;
  logic [0:0] wcnt0;
  logic       ovr0;

  int checks = 0;
  int errors = 0;

  // reference model state
  int q[$];
  int e_avg = 0, e_min = 0, e_max = 0;
  bit e_valid = 0, e_ovr = 0;
  int e_avg0 = 0;
  bit e_valid0 = 0;

  adc_code_averager_if #(.CODE_W(10)) rif ();
  adc_code_averager_if #(.CODE_W(10)) rif0 ();

  adc_code_averager #(.CODE_W(10), .LOG2_AVG(L2)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .enable_i     (en),
    .code_i       (code),
    .code_valid_i (cv),
    .clr_ovr_i    (clr),
    .overrun_o    (ovr),
    .win_cnt_o    (wcnt),
    .res          (rif)
  );

  adc_code_averager #(.CODE_W(10), .LOG2_AVG(0)) dut0 (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .enable_i     (en),
    .code_i       (code),
    .code_valid_i (cv),
    .clr_ovr_i    (clr),
    .overrun_o    (ovr0),
    .win_cnt_o    (wcnt0),
    .res          (rif0)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_val("avg",      32'(rif.avg_o), e_avg);
    check_val("min",      32'(rif.min_o), e_min);
    check_val("max",      32'(rif.max_o), e_max);
    check_val("valid",    32'(rif.avg_valid_o), 32'(e_valid));
    check_val("overrun",  32'(ovr), 32'(e_ovr));
    check_val("win_cnt",  32'(wcnt), q.size());
    check_val("avg0",     32'(rif0.avg_o), e_avg0);
    check_val("min0",     32'(rif0.min_o), e_avg0);
    check_val("max0",     32'(rif0.max_o), e_avg0);
    check_val("valid0",   32'(rif0.avg_valid_o), 32'(e_valid0));
    check_val("overrun0", 32'(ovr0), 0);
    check_val("win_cnt0", 32'(wcnt0), 0);
  endtask

  task automatic model_reset();
    q.delete();
    e_avg = 0; e_min = 0; e_max = 0; e_valid = 0; e_ovr = 0;
    e_avg0 = 0; e_valid0 = 0;
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic step(input bit e, input bit v, input int c, input bit r, input bit cl);
    bit done, drop;
    int s, mn, mx;
    done = 0; s = 0; mn = 1023; mx = 0;
    en = e; cv = v; code = 10'(c); rif.avg_ready_i = r; clr = cl;

    if (e && v) begin
      q.push_back(c);
      if (q.size() == WIN) begin
        done = 1;
        foreach (q[i]) begin
          s += q[i];
          if (q[i] < mn) mn = q[i];
          if (q[i] > mx) mx = q[i];
        end
        q.delete();
      end
    end
    if (!e) q.delete();

    drop = done && e_valid && !r;
    if (done && !drop) begin
      e_avg = s / WIN; e_min = mn; e_max = mx; e_valid = 1;
    end else if (e_valid && r) begin
      e_valid = 0;
    end
    if (drop) e_ovr = 1;
    else if (cl) e_ovr = 0;

    if (e && v) begin
      e_avg0 = c; e_valid0 = 1;
    end else begin
      e_valid0 = 0;
    end

    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic window(input int c, input int n, input bit r_last);
    for (int i = 0; i < n; i++) step(1, 1, c, (i == n - 1) ? r_last : 1'b0, 0);
  endtask

  task automatic read_out();
    step(1, 0, 0, 1, 0);
  endtask

  initial begin
    rif.avg_ready_i  = 1'b0;
    rif0.avg_ready_i = 1'b1;
    model_reset();

    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // disabled strobes are ignored
    for (int i = 0; i < 40; i++) step(0, 1, int'($urandom_range(0, 1023)), 0, 0);

    // basic ramp window
    for (int i = 0; i < 16; i++) step(1, 1, i * 10, 0, 0);
    check_val("basic_avg", 32'(rif.avg_o), 75);
    check_val("basic_max", 32'(rif.max_o), 150);
    read_out();
    check_val("basic_rd_valid", 32'(rif.avg_valid_o), 0);

    // full scale and truncation
    window(1023, 15, 0);
    step(1, 1, 1022, 0, 0);
    check_val("fs_avg", 32'(rif.avg_o), 1022);
    check_val("fs_min", 32'(rif.min_o), 1022);
    read_out();
    for (int i = 0; i < 16; i++) step(1, 1, i % 2, 0, 0);
    check_val("alt_avg", 32'(rif.avg_o), 0);
    read_out();

    // overrun
    window(100, 16, 0);
    window(200, 16, 0);
    check_val("ovr_avg", 32'(rif.avg_o), 100);
    check_val("ovr_flag", 32'(ovr), 1);
    step(1, 0, 0, 0, 1);
    check_val("ovr_clr", 32'(ovr), 0);
    read_out();
    window(100, 16, 0);
    window(200, 16, 1);
    check_val("hs_avg", 32'(rif.avg_o), 200);
    check_val("hs_valid", 32'(rif.avg_valid_o), 1);
    check_val("hs_ovr", 32'(ovr), 0);
    read_out();

    // clear-vs-drop in the same cycle: set wins
    window(50, 16, 0);
    window(60, 15, 0);
    step(1, 1, 60, 0, 1);
    check_val("set_wins", 32'(ovr), 1);
    step(1, 0, 0, 1, 1);

    // enable drop mid-window
    window(500, 7, 0);
    step(0, 1, 500, 0, 0);
    check_val("dis_wcnt", 32'(wcnt), 0);
    window(8, 16, 0);
    check_val("en_avg", 32'(rif.avg_o), 8);
    check_val("en_min", 32'(rif.min_o), 8);
    read_out();

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 1023)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0));

    // async reset mid-window with a pending result
    read_out();
    window(700, 16, 0);
    window(33, 9, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("rst_valid", 32'(rif.avg_valid_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    window(300, 16, 0);
    check_val("post_rst_avg", 32'(rif.avg_o), 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_code_averager.md
Name: adc_code_averager

Overview:
- Downstream stage of the ADC conversion logic. Consumes the 10-bit conversion codes and their valid strobes.
- Accumulates windows of 2^LOG2_AVG codes. For each window it produces the truncated mean plus the min and max codes.
- Results are held in a one-deep output register with a valid/ready handshake toward the readout/Wishbone side.
- Flags overrun when a finished window cannot be delivered.

Parameters:
- CODE_W, 10, width of incoming ADC code
- LOG2_AVG, 4, log2 of window length (window = 16 samples); legal range 0..8

Ports:
- wb_clk_i  in  1  system clock; the only clock
- wb_rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  averaging enable; low discards the partial window
- code_i  in  CODE_W  ADC conversion result
- code_valid_i  in  1  code_i valid this cycle (single-cycle strobe, synchronous to wb_clk_i)
- avg_o  out  CODE_W  window mean, truncated
- min_o  out  CODE_W  smallest code in the window
- max_o  out  CODE_W  largest code in the window
- avg_valid_o  out  1  result register holds an unread result
- avg_ready_i  in  1  consumer accepts the result
- overrun_o  out  1  sticky: a completed window was dropped
- clr_ovr_i  in  1  clears overrun_o
- win_cnt_o  out  LOG2_AVG+1  samples accumulated in the current window

Behaviour:
- Clock and reset:
  - Single clock, wb_clk_i. Reset is asynchronous and active-low on wb_rst_ni.
  - All flops reset asynchronously. Reset values: avg_o=0, min_o=0, max_o=0, avg_valid_o=0, overrun_o=0, win_cnt_o=0.
  - Internal reset values: acc=0, run_min=all-ones, run_max=0.
- Sample acceptance: a sample is accepted when enable_i && code_valid_i.
- Accumulator:
  - Width CODE_W+LOG2_AVG, so it can never overflow.
  - An accepted sample adds code_i to acc, increments win_cnt, and updates run_min/run_max with code_i.
- Window completion: occurs when an accepted sample arrives with win_cnt == 2^LOG2_AVG-1.
  - Computed result: avg = (acc+code_i) >> LOG2_AVG, truncated with no rounding. min/max include that final code.
  - Next cycle: acc=0, win_cnt=0, run_min=all-ones, run_max=0.
  - LOG2_AVG=0: every accepted sample completes a window, and avg=min=max=code_i.
- Output register (1-deep): a result is loaded when the window completes and either avg_valid_o==0 or (avg_valid_o && avg_ready_i) in the same cycle.
  - On load, avg_o/min_o/max_o are updated and avg_valid_o=1 on the cycle after the final sample (latency 1).
  - Otherwise the new result is dropped, the old result is kept unchanged, and overrun_o is set next cycle.
- Handshake:
  - avg_valid_o && avg_ready_i with no completion: avg_valid_o=0 next cycle. avg_o/min_o/max_o keep their last values.
  - Once asserted, avg_valid_o stays high until handshaken.
  - avg_ready_i while avg_valid_o=0 is ignored.
- overrun_o:
  - Sticky. clr_ovr_i clears it next cycle.
  - If clr_ovr_i and a new drop occur in the same cycle, set wins (overrun_o=1).
- enable_i low:
  - acc, win_cnt, run_min and run_max return to their reset values next cycle; no result is produced.
  - Output register and handshake keep operating, so a pending result can still be read.
  - Re-enabling starts a fresh window.
- code_valid_i while enable_i=0 is ignored.
- Reset asserted mid-window or with a pending result: everything is cleared, with no partial output.

Decomposition:
- Shared package adc_pkg:
  - ADC_CODE_W=10
  - typedef adc_code_t
  - localparam for all-ones min seed
  - function clog2 helper for win_cnt width
- One natural sub-module: adc_minmax_tracker. It holds run_min/run_max and takes clear, sample-accept and code inputs.
- Accumulator, counter and output register stay in the top level.

Test Plan:
- Reset/idle: hold wb_rst_ni=0 then release with enable_i=0 and 40 strobes -> all outputs remain at reset values and win_cnt_o=0.
- Basic window (LOG2_AVG=4): 16 accepted codes 0,10,20,...,150 -> one cycle after the 16th: avg_o=75, min_o=0, max_o=150, avg_valid_o=1. Assert avg_ready_i for one cycle -> avg_valid_o=0 next cycle.
- Truncation and full scale:
  - 15 codes of 1023 followed by 1022 -> avg_o=1022 (16367>>4), min_o=1022, max_o=1023. Confirms no accumulator overflow.
  - Codes alternating 0/1 -> avg_o=0.
- Overrun: leave avg_ready_i=0 and complete two windows of constant 100 then 200 -> avg_o stays 100 and overrun_o=1.
  - Pulse clr_ovr_i -> overrun_o=0.
  - Repeat with avg_ready_i=1 exactly on the completion cycle of the second window -> avg_o=200, avg_valid_o stays 1, no overrun.
- Enable drop mid-window: accept 7 codes of 500, deassert enable_i for 1 cycle, then accept 16 codes of 8 -> win_cnt_o returns to 0 while disabled, and the result is avg_o=8, min_o=max_o=8.
- Async reset mid-window: assert wb_rst_ni low asynchronously (between clock edges) after 9 samples with a pending result -> outputs clear immediately. After release, a full window of code 300 -> avg_o=300.
